// File: rtl/parity_check_arbiter_if.sv
// Request/result bus for the parity check arbiter.
// Two requesters present bytes for parity checking; one result channel returns verdicts.
interface parity_check_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_odd;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_odd;
    logic       req1_ready;
    logic       res_valid;
    logic       res_id;
    logic       res_error;
    logic       res_ready;

    // Requesters and result consumer side
    modport master (
        output req0_valid, req0_data, req0_odd,
        input  req0_ready,
        output req1_valid, req1_data, req1_odd,
        input  req1_ready,
        input  res_valid, res_id, res_error,
        output res_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req0_odd,
        output req0_ready,
        input  req1_valid, req1_data, req1_odd,
        output req1_ready,
        output res_valid, res_id, res_error,
        input  res_ready
    );
endinterface

// File: rtl/parity_check_arbiter.sv
// Two-requester round-robin parity checker.
// Accepts one byte at a time, computes its odd/even parity verdict, holds the
// result until consumed and keeps a saturating error count per requester.
module parity_check_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_check_arbiter_if.slave bus,
    output logic [CNT_W-1:0]     err_cnt0,
    output logic [CNT_W-1:0]     err_cnt1,
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg;
    logic             last_reg;       // requester granted last; the other one wins a tie
    logic [7:0]       data_reg;
    logic             odd_reg;
    logic             id_reg;
    logic             err_reg;
    logic             res_valid_reg;
    logic [CNT_W-1:0] cnt_reg [2];

    logic             idle;
    logic             gnt0;
    logic             gnt1;
    logic             res_hs;

    // Grants are combinational so a requester sees ready in the same IDLE cycle.
    // A tie goes to requester 0 unless it was the last one served.
    always_comb begin
        idle   = (state_reg == IDLE) && !rst;
        gnt0   = idle && bus.req0_valid && (!bus.req1_valid || last_reg);
        gnt1   = idle && bus.req1_valid && (!bus.req0_valid || !last_reg);
        res_hs = (state_reg == HOLD) && res_valid_reg && bus.res_ready;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_id     = id_reg;
    assign bus.res_error  = err_reg;
    assign busy           = (state_reg != IDLE) && !rst;
    assign err_cnt0       = cnt_reg[0];
    assign err_cnt1       = cnt_reg[1];

    // Main FSM: capture on grant, evaluate parity, hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            data_reg      <= '0;
            odd_reg       <= 1'b0;
            id_reg        <= 1'b0;
            err_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt0) begin
                        data_reg  <= bus.req0_data;
                        odd_reg   <= bus.req0_odd;
                        id_reg    <= 1'b0;
                        state_reg <= CHECK;
                    end else if (gnt1) begin
                        data_reg  <= bus.req1_data;
                        odd_reg   <= bus.req1_odd;
                        id_reg    <= 1'b1;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    // Parity over all eight bits: even check expects 0, odd check expects 1.
                    err_reg       <= odd_reg ? ~(^data_reg) : (^data_reg);
                    res_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        last_reg      <= id_reg;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    res_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Per-requester saturating error counters, bumped when an erroneous result is consumed.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg[gi] <= '0;
            end else if (res_hs && (id_reg == 1'(gi)) && err_reg && (cnt_reg[gi] != CNT_MAX)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_parity_check_arbiter.sv
// Self-checking bench for parity_check_arbiter: table-driven transactions with a
// result scoreboard, plus sequences for arbitration, backpressure and reset in HOLD.
module tb_parity_check_arbiter;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] err_cnt0;
    logic [CNT_W-1:0] err_cnt1;
    logic             busy;
    int unsigned      cyc = 0;

    parity_check_arbiter_if bus ();

    parity_check_arbiter #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .err_cnt0 (err_cnt0),
        .err_cnt1 (err_cnt1),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       o0;
        logic       v1;
        logic [7:0] d1;
        logic       o1;
        logic       exp_id;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic id;
        logic err;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];
    int   mcnt [2];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic o0,
                         input logic v1, input logic [7:0] d1, input logic o1);
        bus.req0_valid = v0; bus.req0_data = d0; bus.req0_odd = o0;
        bus.req1_valid = v1; bus.req1_data = d1; bus.req1_odd = o1;
    endtask

    // One reset cycle with both requesters asserting, then reset-value checks.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 8'h55, 1'b0, 1'b1, 8'hAA, 1'b1);
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        bus.res_ready = 1'b1;
        mcnt[0] = 0;
        mcnt[1] = 0;
        sb.delete();
        @(negedge clk);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_res_error", bus.res_error, 0);
        check("rst_cnt0", err_cnt0, 0);
        check("rst_cnt1", err_cnt1, 0);
        check("rst_busy_after", busy, 0);
        $display("reset cnt0=%0d cnt1=%0d res_valid=%0d", err_cnt0, err_cnt1, bus.res_valid);
    endtask

    // Apply one table vector: grant check, scoreboard push on accept, pop on result.
    task automatic run_vec(input vec_t v, input int idx);
        int unsigned acc;
        bit          seen;
        exp_t        e;
        @(posedge clk); #1;
        drive(v.v0, v.d0, v.o0, v.v1, v.d1, v.o1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("grant0", bus.req0_ready, v.exp_id == 1'b0);
        check("grant1", bus.req1_ready, v.exp_id == 1'b1);
        if (bus.req0_ready || bus.req1_ready) begin
            acc = cyc;
            sb.push_back('{v.exp_id, v.exp_err});
            @(posedge clk); #1;
            drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            seen = 0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge clk);
                if (bus.res_valid) seen = 1;
            end
            check("res_seen", seen, 1);
            if (seen) begin
                check("latency", cyc - acc, 2);
                e = sb.pop_front();
                check("res_id", bus.res_id, e.id);
                check("res_error", bus.res_error, e.err);
                if (e.err && mcnt[e.id] < CNT_MAX) mcnt[e.id]++;
                @(posedge clk); #1;
                check("cnt0", err_cnt0, mcnt[0]);
                check("cnt1", err_cnt1, mcnt[1]);
                $display("txn %0d id=%0d err=%0d cnt0=%0d cnt1=%0d", idx, bus.res_id, bus.res_error, err_cnt0, err_cnt1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int unsigned acc_cyc [4];
        logic        acc_id  [4];
        bit          seen;

        //        v0  d0     o0  v1  d1     o1  id  err
        vecs[0] = '{1, 8'h81, 1, 0, 8'h00, 0, 0, 1};  // two ones, odd check fails
        vecs[1] = '{0, 8'h00, 0, 1, 8'h81, 0, 1, 0};  // two ones, even check passes
        vecs[2] = '{0, 8'h00, 0, 1, 8'h01, 1, 1, 0};  // one one, odd check passes
        vecs[3] = '{1, 8'h03, 0, 1, 8'h07, 0, 0, 0};  // tie, last was 1 -> 0 wins
        vecs[4] = '{1, 8'h03, 0, 1, 8'h07, 0, 1, 1};  // tie, last was 0 -> 1 wins
        vecs[5] = '{1, 8'h00, 1, 1, 8'hFF, 1, 0, 1};  // tie -> 0, zero ones, odd fails
        vecs[6] = '{1, 8'h7F, 0, 0, 8'h00, 0, 0, 1};  // seven ones, even fails, cnt0 -> 3
        vecs[7] = '{1, 8'h80, 0, 0, 8'h00, 0, 0, 1};  // error again, cnt0 saturates at 3
        vecs[8] = '{0, 8'h00, 0, 1, 8'h00, 0, 1, 0};  // zero ones, even passes

        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        bus.res_ready = 1'b0;
        do_reset();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Both requesters held valid: grants must alternate, one accept every 3 cycles.
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        bus.res_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                check("rr_onehot", bus.req0_ready & bus.req1_ready, 0);
                acc_cyc[n] = cyc;
                acc_id[n]  = bus.req1_ready;
                n++;
            end
        end
        check("rr_accepts", n, 4);
        for (int i = 0; i < n; i++) begin
            check("rr_id", acc_id[i], i % 2);
            if (i > 0) check("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
            $display("rr accept %0d id=%0d cycle=%0d", i, acc_id[i], acc_cyc[i]);
        end
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rr_cnt0", err_cnt0, 0);
        check("rr_cnt1", err_cnt1, 0);

        // Backpressure in HOLD: result and readys frozen while res_ready is low.
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0);
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("hold_grant0", bus.req0_ready, 1);
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1;
        end
        check("hold_seen", seen, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", bus.res_valid, 1);
            check("hold_id", bus.res_id, 0);
            check("hold_error", bus.res_error, 1);
            check("hold_ready0", bus.req0_ready, 0);
            check("hold_ready1", bus.req1_ready, 0);
            check("hold_busy", busy, 1);
        end
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_busy", busy, 0);
        check("release_valid", bus.res_valid, 0);
        check("release_cnt0", err_cnt0, 1);
        $display("hold release id=0 err=1 cnt0=%0d busy=%0d", err_cnt0, busy);

        // Reset while a requester-1 result is held: result dropped, pointer back to 0.
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0);
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("rh_grant1", bus.req1_ready, 1);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1;
        end
        check("rh_seen", seen, 1);
        do_reset();
        @(posedge clk); #1;
        drive(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        check("rh_first_grant0", bus.req0_ready, 1);
        check("rh_first_grant1", bus.req1_ready, 0);
        $display("reset in hold: first grant ready0=%0d ready1=%0d", bus.req0_ready, bus.req1_ready);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        bus.res_ready = 1'b1;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/parity_check_arbiter.md
PARITY_CHECK_ARBITER -- requirements
Module: parity_check_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of each per-requester error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a byte to check.
REQ-005 req0_data  input  8  bits [6:0] data, bit [7] parity bit.
REQ-006 req0_odd  input  1  1 = odd-parity check, 0 = even-parity check; sampled with req0_data.
REQ-007 req0_ready  output  1  block accepts requester 0 this cycle.
REQ-008 req1_valid, req1_data, req1_odd, req1_ready: same widths, directions and meanings as REQ-004..007, for requester 1.
REQ-009 res_valid  output  1  result available.
REQ-010 res_id  output  1  requester index of the current result.
REQ-011 res_error  output  1  0 = parity correct, 1 = parity error.
REQ-012 res_ready  input  1  downstream consumes result.
REQ-013 err_cnt0, err_cnt1  output  CNT_W  saturating error counts per requester.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, CHECK, HOLD; encoding is free.
REQ-016 IDLE: if exactly one reqN_valid is high, reqN_ready = 1 that cycle; if both are high, only the round-robin winner's ready = 1; other ready = 0.
REQ-017 Round robin: winner is the requester not granted last; pointer after reset favours requester 0.
REQ-018 Transfer occurs when reqN_valid & reqN_ready; data, odd flag and id are registered; next state CHECK.
REQ-019 reqN_ready is 0 in CHECK and HOLD.
REQ-020 CHECK: p = XOR of all 8 captured bits; res_error = (odd ? ~p : p), registered; next state HOLD.
REQ-021 HOLD: res_valid = 1; res_id, res_error stable until res_valid & res_ready.
REQ-022 On the HOLD handshake cycle: the counter selected by res_id increments by 1 if res_error = 1; pointer records res_id as last granted; next state IDLE.
REQ-023 Counters saturate at 2^CNT_W-1; no wrap.
REQ-024 Latency: transfer in cycle N, res_valid first high in cycle N+2; minimum 3 cycles between accepts.
REQ-025 A requester dropping valid in a cycle where it has no ready is legal; no grant is issued and the pointer is unchanged.
REQ-026 res_ready while res_valid = 0 is ignored.
REQ-027 A requester's data changes while ready = 0 have no effect.

Reset
REQ-028 While rst = 1 at a rising edge: state IDLE, pointer favours requester 0, err_cnt0 = err_cnt1 = 0, res_valid = 0, res_id = 0, res_error = 0.
REQ-029 Reset in CHECK or HOLD discards the in-flight result; no counter update, no result delivered.
REQ-030 req0_ready, req1_ready and busy are 0 during the rst cycle.

Verification
REQ-031 Req0 only, data 8'h81, odd=1 (two ones) -> req0_ready in cycle N, res_valid at N+2, res_id=0, res_error=1, err_cnt0=1 after the handshake.
REQ-032 Req1 only, data 8'h81, odd=0 -> res_id=1, res_error=0, err_cnt1 unchanged; data 8'h01, odd=1 -> res_error=0.
REQ-033 Both valid continuously after reset, res_ready=1 -> grants alternate 0,1,0,1; one accept every 3 cycles.
REQ-034 res_ready held 0 for 5 cycles in HOLD -> res_valid, res_id, res_error constant, both readys 0; release -> IDLE next cycle.
REQ-035 Error stream on req0 with CNT_W=2 -> err_cnt0 counts 1,2,3 and stays 3.
REQ-036 rst asserted in HOLD -> next cycle res_valid=0, counters 0, first new grant goes to requester 0.
